alu_frame_sequencer: RTL
========================

# alu_frame_sequencer

Framed command controller between the UART byte interface and the combinational ALU. Receives a 5-byte command frame (sync, A, B, opcode, checksum) from UART RX, drives the ALU operands, and latches the result. It then returns a 3-byte response frame (sync, result, status) through UART TX, handshaking on the TX done tick for each byte. The UART and the ALU connect to it directly.

## Interface
- `DATA_SIZE`, 8: operand and result width; UART byte width is fixed at 8, and `DATA_SIZE` must be 8.
- `OPCODE_SIZE`, 6: ALU opcode width; taken from the low bits of the opcode byte.
- `SYNC_BYTE`, 8'hA5: frame start marker, used in both directions.
- `TIMEOUT_CYCLES`, 50000: inter-byte timeout in `i_clk` cycles (only when `RX_TIMEOUT_EN` is defined).

- `i_clk`  in  1: single clock.
- `i_reset`  in  1: synchronous, active-high reset.
- `i_rx_done_tick`  in  1: one-cycle pulse, `i_rx_data` valid.
- `i_rx_data`  in  8: received byte.
- `i_tx_done_tick`  in  1: one-cycle pulse when the UART finishes a TX byte.
- `i_res_alu`  in  DATA_SIZE: ALU result (combinational from `o_a`, `o_b`, `o_opcode`).
- `o_a`  out  DATA_SIZE: ALU operand A (registered).
- `o_b`  out  DATA_SIZE: ALU operand B (registered).
- `o_opcode`  out  OPCODE_SIZE: ALU opcode (registered).
- `o_tx_data`  out  8: byte to transmit.
- `o_tx_start`  out  1: one-cycle TX start pulse.
- `o_busy`  out  1: high in every state except IDLE.
- `o_err`  out  1: one-cycle pulse on a checksum error or a timeout.

## Operation
- FSM states: IDLE, GET_A, GET_B, GET_OP, GET_CHK, EXEC, TX_SYNC, TX_RES, TX_STAT.
- IDLE:
  - an RX byte equal to `SYNC_BYTE` → GET_A;
  - any other byte is discarded.
- GET_A, GET_B, GET_OP: each RX byte loads `o_a`, `o_b`, `o_opcode` (byte[5:0]) respectively and advances the state.
- Operand registers hold their value until overwritten by the next frame.
- GET_CHK: the RX byte is compared against A ^ B ^ OPbyte (the full 8-bit opcode byte), then → EXEC.
- EXEC (one cycle):
  - checksum good: result register ← `i_res_alu`, status ← 8'h00;
  - checksum bad: result ← 8'h00, status ← 8'h01, and `o_err` pulses.
- TX_SYNC, TX_RES, TX_STAT:
  - on entry, `o_tx_data` is set to `SYNC_BYTE`, the result, or the status respectively, and `o_tx_start` pulses;
  - each state waits for `i_tx_done_tick`, then advances; TX_STAT → IDLE.
- RX bytes arriving in EXEC or any TX state are dropped, with no buffering.
- `i_tx_done_tick` outside the TX states is ignored.
- A sync-valued byte received while in GET_* is treated as data, not as a resync.

## Timing
- Reset values: state IDLE; `o_a`, `o_b`, `o_opcode`, `o_tx_data`, result and status all 0; `o_tx_start`, `o_busy`, `o_err` all 0.
- Checksum byte tick at cycle N:
  - EXEC at N+1;
  - TX_SYNC at N+2, with `o_tx_start`=1 and `o_tx_data`=`SYNC_BYTE` in that cycle.
- `i_tx_done_tick` at cycle M → next TX state entered at M+1, with its `o_tx_start` pulse in M+1.
- `o_tx_data` is stable from its start pulse through the matching done tick.
- `o_tx_start` is never high for two consecutive cycles.
- An RX tick and a TX tick in the same cycle are evaluated independently; only the one relevant to the current state acts.
- Reset mid-frame or mid-response: next cycle is IDLE with reset values.
  - A UART byte already in flight completes.
  - Its done tick lands in IDLE and is ignored.

## Configuration
- Macro `RX_TIMEOUT_EN`, defined:
  - a counter clears on entry to GET_A and on every accepted byte in GET_A to GET_CHK;
  - it counts while in those states;
  - reaching `TIMEOUT_CYCLES`-1 with no byte → IDLE next cycle, `o_err` pulse, no response sent, operands keep partial values.
- Not defined: no counter; a partial frame waits indefinitely.

## Structure
- Package `alu_link_pkg`:
  - state enum;
  - `SYNC_BYTE` default;
  - status codes `STAT_OK`=8'h00, `STAT_CHK`=8'h01.
- One sub-module, `rx_watchdog`: the timeout counter with clear, enable and expired outputs, instantiated only under `RX_TIMEOUT_EN`.

## Test plan
- Good frame: RX A5,05,03,20,26 with the ALU model computing ADD → `o_a`=05, `o_b`=03, `o_opcode`=20; TX A5,08,00; one `o_err`-free pass; `o_busy` low afterwards.
- Bad checksum: RX A5,05,03,20,FF → `o_err` pulse at EXEC; TX A5,00,01.
- Garbage before sync: RX 11,22,A5,… (valid frame) → bytes 11 and 22 ignored; normal response.
- RX during response: inject byte 7E between TX_SYNC start and done → byte dropped; response unchanged; FSM returns to IDLE.
- Reset after GET_B: all outputs return to reset values next cycle; a late `i_tx_done_tick` is ignored; a following full frame is processed correctly.
- `RX_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100: RX A5,05 then silence → IDLE plus `o_err` pulse 100 cycles after the last byte, with no TX; without the macro, the FSM is still in GET_B after 10000 cycles.

Source files
------------

// File: rtl/alu_link_pkg.sv
// Shared types and constants for the UART <-> ALU framed command link.
package alu_link_pkg;

   // Sequencer states: receive a 5-byte command, execute, send a 3-byte reply.
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_GET_A,
      ST_GET_B,
      ST_GET_OP,
      ST_GET_CHK,
      ST_EXEC,
      ST_TX_SYNC,
      ST_TX_RES,
      ST_TX_STAT
   } seq_state_t;

   // Frame start marker used for both command and response frames.
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // Status byte values returned in the response frame.
   localparam logic [7:0] STAT_OK  = 8'h00;
   localparam logic [7:0] STAT_CHK = 8'h01;

endpackage

// File: rtl/alu_frame_sequencer_if.sv
// Bundles the UART byte handshake and the ALU operand/result lines.
// master: the sequencer side; slave: the UART/ALU side.
interface alu_frame_sequencer_if #(
   parameter int DATA_SIZE   = 8,
   parameter int OPCODE_SIZE = 6
);
   logic                   i_rx_done_tick;
   logic [7:0]             i_rx_data;
   logic                   i_tx_done_tick;
   logic [DATA_SIZE-1:0]   i_res_alu;
   logic [DATA_SIZE-1:0]   o_a;
   logic [DATA_SIZE-1:0]   o_b;
   logic [OPCODE_SIZE-1:0] o_opcode;
   logic [7:0]             o_tx_data;
   logic                   o_tx_start;
   logic                   o_busy;
   logic                   o_err;

   modport master (
      input  i_rx_done_tick, i_rx_data, i_tx_done_tick, i_res_alu,
      output o_a, o_b, o_opcode, o_tx_data, o_tx_start, o_busy, o_err
   );

   modport slave (
      output i_rx_done_tick, i_rx_data, i_tx_done_tick, i_res_alu,
      input  o_a, o_b, o_opcode, o_tx_data, o_tx_start, o_busy, o_err
   );
endinterface

// File: rtl/alu_frame_sequencer_rx_watchdog.sv
// Inter-byte timeout counter: clears on demand, counts while enabled,
// and flags expiry on the last cycle of the allowed window.
module rx_watchdog #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Clear has priority so an accepted byte always restarts the window.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i) begin
         count_d = count_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = enable_i && !clear_i && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_frame_sequencer.sv
// Framed command controller between a UART byte interface and a
// combinational ALU. Optional inter-byte timeout: define RX_TIMEOUT_EN.
module alu_frame_sequencer
   import alu_link_pkg::*;
#(
   parameter int         DATA_SIZE      = 8,
   parameter int         OPCODE_SIZE    = 6,
   parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
   parameter int         TIMEOUT_CYCLES = 50000
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   alu_frame_sequencer_if.master bus
);
   // The UART byte is fixed at 8 bits, so operands and results must match it.
   if (DATA_SIZE != 8) begin : g_bad_data_size
      $error("alu_frame_sequencer: DATA_SIZE must be 8");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("alu_frame_sequencer: TIMEOUT_CYCLES must be at least 2");
   end

   seq_state_t             state_q, state_d;
   logic [DATA_SIZE-1:0]   a_q, a_d;
   logic [DATA_SIZE-1:0]   b_q, b_d;
   logic [OPCODE_SIZE-1:0] op_q, op_d;
   logic [7:0]             opByte_q, opByte_d;
   logic                   chkOk_q, chkOk_d;
   logic [DATA_SIZE-1:0]   result_q, result_d;
   logic [7:0]             status_q, status_d;
   logic [7:0]             txData_q, txData_d;
   logic                   txStart_q, txStart_d;
   logic                   err_q, err_d;
   logic                   timeoutHit;
   logic                   chkMatch;

   // The checksum covers the whole opcode byte, not just the opcode bits.
   assign chkMatch = (bus.i_rx_data == (a_q ^ b_q ^ opByte_q));

`ifdef RX_TIMEOUT_EN
   logic inFrame;
   logic wdClear;

   assign inFrame = (state_q == ST_GET_A) || (state_q == ST_GET_B) ||
                    (state_q == ST_GET_OP) || (state_q == ST_GET_CHK);
   assign wdClear = bus.i_rx_done_tick &&
                    (inFrame || ((state_q == ST_IDLE) && (bus.i_rx_data == SYNC_BYTE)));

   rx_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx_watchdog (
      .clock_i   (i_clk),
      .reset_i   (i_reset),
      .clear_i   (wdClear),
      .enable_i  (inFrame),
      .expired_o (timeoutHit)
   );
`else
   assign timeoutHit = 1'b0;
`endif

   // Next-state and register updates; TX start is a pulse raised only on entry to a TX state.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      opByte_d  = opByte_q;
      chkOk_d   = chkOk_q;
      result_d  = result_q;
      status_d  = status_q;
      txData_d  = txData_q;
      txStart_d = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.i_rx_done_tick && (bus.i_rx_data == SYNC_BYTE)) begin
               state_d = ST_GET_A;
            end
         end
         ST_GET_A: begin
            if (bus.i_rx_done_tick) begin
               a_d     = bus.i_rx_data;
               state_d = ST_GET_B;
            end else if (timeoutHit) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end
         ST_GET_B: begin
            if (bus.i_rx_done_tick) begin
               b_d     = bus.i_rx_data;
               state_d = ST_GET_OP;
            end else if (timeoutHit) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end
         ST_GET_OP: begin
            if (bus.i_rx_done_tick) begin
               op_d     = bus.i_rx_data[OPCODE_SIZE-1:0];
               opByte_d = bus.i_rx_data;
               state_d  = ST_GET_CHK;
            end else if (timeoutHit) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end
         ST_GET_CHK: begin
            if (bus.i_rx_done_tick) begin
               chkOk_d = chkMatch;
               err_d   = !chkMatch;
               state_d = ST_EXEC;
            end else if (timeoutHit) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end
         end
         ST_EXEC: begin
            if (chkOk_q) begin
               result_d = bus.i_res_alu;
               status_d = STAT_OK;
            end else begin
               result_d = '0;
               status_d = STAT_CHK;
            end
            txData_d  = SYNC_BYTE;
            txStart_d = 1'b1;
            state_d   = ST_TX_SYNC;
         end
         ST_TX_SYNC: begin
            if (bus.i_tx_done_tick) begin
               txData_d  = result_q;
               txStart_d = 1'b1;
               state_d   = ST_TX_RES;
            end
         end
         ST_TX_RES: begin
            if (bus.i_tx_done_tick) begin
               txData_d  = status_q;
               txStart_d = 1'b1;
               state_d   = ST_TX_STAT;
            end
         end
         ST_TX_STAT: begin
            if (bus.i_tx_done_tick) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         opByte_q  <= '0;
         chkOk_q   <= 1'b0;
         result_q  <= '0;
         status_q  <= '0;
         txData_q  <= '0;
         txStart_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         opByte_q  <= opByte_d;
         chkOk_q   <= chkOk_d;
         result_q  <= result_d;
         status_q  <= status_d;
         txData_q  <= txData_d;
         txStart_q <= txStart_d;
         err_q     <= err_d;
      end
   end

   assign bus.o_a        = a_q;
   assign bus.o_b        = b_q;
   assign bus.o_opcode   = op_q;
   assign bus.o_tx_data  = txData_q;
   assign bus.o_tx_start = txStart_q;
   assign bus.o_busy     = (state_q != ST_IDLE);
   assign bus.o_err      = err_q;

endmodule
